// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between instruction fetch and
// data (load/store) requests. Data normally wins, but a waiting fetch is
// guaranteed a grant after MAX_DATA_BURST data grants in a row.
// Optional build macro MEM_TIMEOUT_EN adds a wait-for-ack watchdog that aborts
// a stuck access after TIMEOUT_CYCLES cycles and raises a sticky o_err.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_valid,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_stall_if,
  output logic              o_stall_mem,
  output logic              o_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DATA
  } state_t;

  localparam int BW = $clog2(MAX_DATA_BURST + 1);

  state_t        r_state;
  state_t        w_next;
  logic [BW-1:0] r_burst;
  logic          w_starved;
  logic          w_grant_d;
  logic          w_grant_f;
  logic          w_ack;
  logic          w_expire;
  logic          w_tmo_hit;

  // A waiting fetch has lost MAX_DATA_BURST data grants in a row and now wins.
  assign w_starved = i_if_req && (r_burst == BW'(MAX_DATA_BURST));

`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo;
  logic          r_err;

  // The current cycle is the last one allowed before the access is abandoned.
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYCLES - 1));

  // Count busy cycles without ack; restart whenever the port goes idle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tmo <= '0;
    end else if ((r_state != S_IDLE) && !w_ack && !w_expire) begin
      r_tmo <= r_tmo + TW'(1);
    end else begin
      r_tmo <= '0;
    end
  end

  // Remember any abandoned access until the next reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err <= 1'b0;
    end else if (w_expire) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  // No watchdog: an access waits for its ack forever. The comparison is
  // constant-false and only keeps the parameter referenced in this build.
  assign w_tmo_hit = (TIMEOUT_CYCLES < 0);
  assign o_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and grant decode; ack wins over a same-cycle timeout.
  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_f = 1'b0;
    w_ack     = 1'b0;
    w_expire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_d_req && !w_starved) begin
          w_next    = S_DATA;
          w_grant_d = 1'b1;
        end else if (i_if_req) begin
          w_next    = S_FETCH;
          w_grant_f = 1'b1;
        end
      end
      S_FETCH, S_DATA: begin
        if (i_mem_ack) begin
          w_ack  = 1'b1;
          w_next = S_IDLE;
        end else if (w_tmo_hit) begin
          w_expire = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Consecutive data grants while a fetch waits; any fetch grant clears it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_burst <= '0;
    end else if (w_grant_f) begin
      r_burst <= '0;
    end else if (w_grant_d && i_if_req && (r_burst != BW'(MAX_DATA_BURST))) begin
      r_burst <= r_burst + BW'(1);
    end
  end

  // Memory request registers, completion pulses and returned read data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_if_valid  <= 1'b0;
      o_d_valid   <= 1'b0;
      o_if_rdata  <= '0;
      o_d_rdata   <= '0;
    end else begin
      o_if_valid <= (r_state == S_FETCH) && (w_ack || w_expire);
      o_d_valid  <= (r_state == S_DATA) && (w_ack || w_expire);
      if (w_grant_d) begin
        o_mem_en    <= 1'b1;
        o_mem_we    <= i_d_we;
        o_mem_addr  <= i_d_addr;
        o_mem_wdata <= i_d_wdata;
      end else if (w_grant_f) begin
        o_mem_en    <= 1'b1;
        o_mem_we    <= 1'b0;
        o_mem_addr  <= i_if_addr;
        o_mem_wdata <= '0;
      end else if (w_ack || w_expire) begin
        o_mem_en <= 1'b0;
        o_mem_we <= 1'b0;
      end
      if ((r_state == S_FETCH) && (w_ack || w_expire)) begin
        o_if_rdata <= w_ack ? i_mem_rdata : '0;
      end
      if ((r_state == S_DATA) && (w_expire || (w_ack && !o_mem_we))) begin
        o_d_rdata <= w_ack ? i_mem_rdata : '0;
      end
    end
  end

  assign o_stall_if  = i_if_req & ~o_if_valid;
  assign o_stall_mem = i_d_req & ~o_d_valid;

endmodule
